// File: rtl/ha_seq_pkg.sv
// ----------------------------------------------------------------------------
// ha_seq_pkg
// Shared definitions for the half-adder-array sequencing controller:
//   N_GRP/B_W/T_W  : array geometry (4 groups of 7-bit b / 9-bit t vectors)
//   ACC_W/PROD_W   : accumulator and product widths
//   state_t        : controller states
//   grp_weight()   : W_g = (t_g + (b_g << 2)) << (2g), zero-extended to ACC_W
// ----------------------------------------------------------------------------
package ha_seq_pkg;

    localparam int N_GRP  = 4;
    localparam int B_W    = 7;
    localparam int T_W    = 9;
    localparam int ACC_W  = 18;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic logic [ACC_W-1:0] grp_weight(
        input logic [B_W-1:0] b,
        input logic [T_W-1:0] t,
        input logic [1:0]     g
    );
        logic [10:0] inner;
        inner = 11'(t) + (11'(b) << 2);
        return ACC_W'(inner) << {g, 1'b0};
    endfunction

endpackage

// File: rtl/ha_grp_weight.sv
// ----------------------------------------------------------------------------
// ha_grp_weight
// Combinational weighting of one returned array group.
//   i_b   : group carry vector
//   i_t   : group sum vector
//   i_grp : group index (selects the 4^g shift)
//   o_w   : weighted term, ACC_W bits
// ----------------------------------------------------------------------------
module ha_grp_weight
    import ha_seq_pkg::*;
(
    input  logic [B_W-1:0]   i_b,
    input  logic [T_W-1:0]   i_t,
    input  logic [1:0]       i_grp,
    output logic [ACC_W-1:0] o_w
);

    assign o_w = grp_weight(i_b, i_t, i_grp);

endmodule

// File: rtl/ha_array_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ha_array_seq_ctrl
// Sequences one 8x8 half-adder-array partial-product generator: accepts an
// operand pair, holds it on the array inputs, reduces the four returned groups
// into a 16-bit product over N_ACC = 4/GRP_PER_CYC cycles, then offers it.
//   clk, rst              : clock (rising), asynchronous active-high reset
//   in_valid/in_ready     : operand handshake, x_in/y_in operands
//   arr_x/arr_y           : registered operands driven to the array
//   ha_array_<g>_b/_t     : group g carry / sum vectors returned by the array
//   out_valid/out_ready   : result handshake, product = reduced result
//   busy                  : high in any state other than IDLE
// ----------------------------------------------------------------------------
module ha_array_seq_ctrl
    import ha_seq_pkg::*;
#(
    parameter int GRP_PER_CYC = 1,
    parameter bit SAT_EN      = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    output logic [7:0]        arr_x,
    output logic [7:0]        arr_y,
    input  logic [B_W-1:0]    ha_array_0_b,
    input  logic [B_W-1:0]    ha_array_1_b,
    input  logic [B_W-1:0]    ha_array_2_b,
    input  logic [B_W-1:0]    ha_array_3_b,
    input  logic [T_W-1:0]    ha_array_0_t,
    input  logic [T_W-1:0]    ha_array_1_t,
    input  logic [T_W-1:0]    ha_array_2_t,
    input  logic [T_W-1:0]    ha_array_3_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam int          N_ACC   = N_GRP / GRP_PER_CYC;
    localparam int unsigned N_TERMS = GRP_PER_CYC;

    if (!(GRP_PER_CYC == 1 || GRP_PER_CYC == 2 || GRP_PER_CYC == 4)) begin : g_bad_grp
        $error("ha_array_seq_ctrl: GRP_PER_CYC must be 1, 2 or 4");
    end

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_arr_x;
    logic [7:0]          r_arr_y;
    logic [ACC_W-1:0]    r_acc;
    logic [1:0]          r_cnt;
    logic [PROD_W-1:0]   r_product;

    logic                w_load;
    logic                w_acc_en;
    logic                w_last;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [PROD_W-1:0]   w_prod_next;

    logic [B_W-1:0]      w_b_all [N_GRP];
    logic [T_W-1:0]      w_t_all [N_GRP];
    logic [1:0]          w_gidx  [GRP_PER_CYC];
    logic [ACC_W-1:0]    w_term  [GRP_PER_CYC];

    assign w_b_all[0] = ha_array_0_b;
    assign w_b_all[1] = ha_array_1_b;
    assign w_b_all[2] = ha_array_2_b;
    assign w_b_all[3] = ha_array_3_b;
    assign w_t_all[0] = ha_array_0_t;
    assign w_t_all[1] = ha_array_1_t;
    assign w_t_all[2] = ha_array_2_t;
    assign w_t_all[3] = ha_array_3_t;

    // Slot k of cycle cnt handles group cnt*GRP_PER_CYC + k.
    for (genvar k = 0; k < GRP_PER_CYC; k++) begin : g_term
        assign w_gidx[k] = 2'(int'(r_cnt) * GRP_PER_CYC + k);

        ha_grp_weight u_grp_weight (
            .i_b   (w_b_all[w_gidx[k]]),
            .i_t   (w_t_all[w_gidx[k]]),
            .i_grp (w_gidx[k]),
            .o_w   (w_term[k])
        );
    end

    always_comb begin
        w_acc_sum = r_acc;
        for (int unsigned k = 0; k < N_TERMS; k++) begin
            w_acc_sum = w_acc_sum + w_term[k];
        end
    end

    assign w_last      = (r_cnt == 2'(N_ACC - 1));
    assign w_prod_next = (SAT_EN && (|w_acc_sum[ACC_W-1:PROD_W])) ? '1 : w_acc_sum[PROD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE with out_ready and in_valid reloads directly into ACC (no IDLE bubble).
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_load    = 1'b0;
        w_acc_en  = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ACC;
                end
            end
            ACC: begin
                w_acc_en = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    w_load   = in_valid;
                    w_next   = in_valid ? ACC : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arr_x   <= '0;
            r_arr_y   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_arr_x <= x_in;
            r_arr_y <= y_in;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_acc_en) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
                r_product <= w_prod_next;
            end
        end
    end

    assign arr_x   = r_arr_x;
    assign arr_y   = r_arr_y;
    assign product = r_product;

endmodule

// File: tb/tb_ha_array_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ha_array_seq_ctrl
// Four controller instances (GRP_PER_CYC/SAT_EN = 1/1, 1/0, 4/1, 2/0) driven
// one at a time. The driver pushes the expected product (arithmetic model of
// the group weighting) when an operand pair is accepted; a per-instance
// monitor checks latency on each new result and the product on handshake.
// ----------------------------------------------------------------------------
module tb_ha_array_seq_ctrl;

    localparam int ND = 4;

    function automatic int gpc_of(input int d);
        case (d)
            0, 1:    return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic bit sat_of(input int d);
        return (d == 0 || d == 2);
    endfunction

    typedef struct {
        int          d;
        logic [15:0] p;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [ND];
    logic       in_ready  [ND];
    logic [7:0] x_in      [ND];
    logic [7:0] y_in      [ND];
    logic [7:0] arr_x     [ND];
    logic [7:0] arr_y     [ND];
    logic [6:0] gb        [ND][4];
    logic [8:0] gt        [ND][4];
    logic       out_valid [ND];
    logic       out_ready [ND];
    logic [15:0] product  [ND];
    logic       busy      [ND];
    logic       rr_en     [ND];
    logic       man_rdy   [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, d, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int d);
        n_vec++;
        n_err++;
        $display("FAIL %s dut%0d: got no/unexpected event, expected the scheduled one", nm, d);
    endtask

    // Reference: sum over groups of (t + 4b) * 4^g, then clamp or wrap.
    function automatic logic [15:0] model(input logic [6:0] bv[4], input logic [8:0] tv[4], input bit sat);
        longint s = 0;
        for (int g = 0; g < 4; g++) begin
            s += (longint'(tv[g]) + 4 * longint'(bv[g])) * (longint'(1) << (2 * g));
        end
        if (sat && s > 65535) return 16'hFFFF;
        return 16'(s);
    endfunction

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        localparam int NACC = 4 / gpc_of(gi);
        logic rnd_rdy = 1'b1;
        logic prev_ov = 1'b0;
        logic prev_hs = 1'b0;

        ha_array_seq_ctrl #(.GRP_PER_CYC(gpc_of(gi)), .SAT_EN(sat_of(gi))) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid[gi]),
            .in_ready     (in_ready[gi]),
            .x_in         (x_in[gi]),
            .y_in         (y_in[gi]),
            .arr_x        (arr_x[gi]),
            .arr_y        (arr_y[gi]),
            .ha_array_0_b (gb[gi][0]),
            .ha_array_1_b (gb[gi][1]),
            .ha_array_2_b (gb[gi][2]),
            .ha_array_3_b (gb[gi][3]),
            .ha_array_0_t (gt[gi][0]),
            .ha_array_1_t (gt[gi][1]),
            .ha_array_2_t (gt[gi][2]),
            .ha_array_3_t (gt[gi][3]),
            .out_valid    (out_valid[gi]),
            .out_ready    (out_ready[gi]),
            .product      (product[gi]),
            .busy         (busy[gi])
        );

        assign out_ready[gi] = rr_en[gi] ? rnd_rdy : man_rdy[gi];

        always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

        // Latency is counted from the cycle the handshake is presented to the
        // first cycle out_valid is seen: N_ACC accumulate cycles plus one.
        always @(negedge clk) begin
            if (rst) begin
                prev_ov <= 1'b0;
                prev_hs <= 1'b0;
            end else begin
                if (out_valid[gi] && (!prev_ov || prev_hs)) begin
                    if (sbq.size() == 0 || sbq[0].d != gi) fail("unexpected_result", gi);
                    else chk("latency", gi, 32'(cyc - sbq[0].acc_cyc), 32'(NACC + 1));
                end
                if (out_valid[gi] && out_ready[gi]) begin
                    if (sbq.size() == 0 || sbq[0].d != gi) begin
                        fail("unexpected_handshake", gi);
                    end else begin
                        chk("product", gi, 32'(product[gi]), 32'(sbq[0].p));
                        void'(sbq.pop_front());
                    end
                end
                prev_ov <= out_valid[gi];
                prev_hs <= out_valid[gi] && out_ready[gi];
            end
        end
    end

    task automatic garbage(input int d);
        for (int g = 0; g < 4; g++) begin
            gb[d][g] = 7'($urandom);
            gt[d][g] = 9'($urandom);
        end
    endtask

    task automatic check_reset(input int d);
        chk("rst_arr_x", d, 32'(arr_x[d]), 32'd0);
        chk("rst_arr_y", d, 32'(arr_y[d]), 32'd0);
        chk("rst_product", d, 32'(product[d]), 32'd0);
        chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
        chk("rst_busy", d, 32'(busy[d]), 32'd0);
        chk("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
    endtask

    task automatic do_txn(input int d, input logic [7:0] x, input logic [7:0] y,
                          input logic [6:0] bv[4], input logic [8:0] tv[4],
                          input int idle, output int waits);
        bit accepted = 1'b0;
        int n = 0;
        waits = 0;
        repeat (idle) begin
            in_valid[d] = 1'b0;
            garbage(d);
            @(posedge clk); #1;
        end
        x_in[d] = x;
        y_in[d] = y;
        in_valid[d] = 1'b1;
        while (!accepted && waits < 100) begin
            garbage(d);
            @(negedge clk);
            if (in_ready[d]) begin
                accepted = 1'b1;
                sbq.push_back('{d: d, p: model(bv, tv, sat_of(d)), acc_cyc: cyc});
            end
            @(posedge clk); #1;
            if (!accepted) waits++;
        end
        in_valid[d] = 1'b0;
        if (!accepted) begin
            fail("accept_timeout", d);
            return;
        end
        for (int g = 0; g < 4; g++) begin
            gb[d][g] = bv[g];
            gt[d][g] = tv[g];
        end
        x_in[d] = 8'($urandom);
        y_in[d] = 8'($urandom);
        chk("busy_after_accept", d, 32'(busy[d]), 32'd1);
        while (!out_valid[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid[d]) begin
            fail("done_timeout", d);
        end else begin
            chk("arr_x", d, 32'(arr_x[d]), 32'(x));
            chk("arr_y", d, 32'(arr_y[d]), 32'(y));
        end
        garbage(d);
    endtask

    task automatic rand_txn(input int d, input int idle);
        logic [6:0] bv[4];
        logic [8:0] tv[4];
        int w;
        for (int g = 0; g < 4; g++) begin
            bv[g] = 7'($urandom);
            tv[g] = 9'($urandom);
        end
        do_txn(d, 8'($urandom), 8'($urandom), bv, tv, idle, w);
    endtask

    task automatic drain();
        int n = 0;
        for (int d = 0; d < ND; d++) begin
            rr_en[d]   = 1'b0;
            man_rdy[d] = 1'b1;
        end
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            fail("drain_timeout", sbq[0].d);
            sbq.delete();
        end
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) rr_en[d] = 1'b1;
    endtask

    task automatic backpressure(input int d);
        logic [6:0] bv[4];
        logic [8:0] tv[4];
        logic [7:0] x, y;
        logic [15:0] e;
        int w;
        for (int g = 0; g < 4; g++) begin
            bv[g] = 7'($urandom);
            tv[g] = 9'($urandom);
        end
        x = 8'($urandom);
        y = 8'($urandom);
        e = model(bv, tv, sat_of(d));
        rr_en[d]   = 1'b0;
        man_rdy[d] = 1'b0;
        do_txn(d, x, y, bv, tv, 0, w);
        in_valid[d] = 1'b1;
        x_in[d] = ~x;
        y_in[d] = ~y;
        for (int i = 0; i < 10; i++) begin
            garbage(d);
            @(negedge clk);
            chk("bp_out_valid", d, 32'(out_valid[d]), 32'd1);
            chk("bp_product", d, 32'(product[d]), 32'(e));
            chk("bp_arr_x", d, 32'(arr_x[d]), 32'(x));
            chk("bp_arr_y", d, 32'(arr_y[d]), 32'(y));
            chk("bp_in_ready", d, 32'(in_ready[d]), 32'd0);
            chk("bp_busy", d, 32'(busy[d]), 32'd1);
            @(posedge clk); #1;
        end
        man_rdy[d] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            bv[g] = 7'($urandom);
            tv[g] = 9'($urandom);
        end
        do_txn(d, 8'($urandom), 8'($urandom), bv, tv, 0, w);
        chk("bp_accept_same_cycle", d, 32'(w), 32'd0);
        rr_en[d] = 1'b1;
    endtask

    initial begin
        logic [6:0] bv[4];
        logic [8:0] tv[4];
        int w;

        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0;
            x_in[d]     = '0;
            y_in[d]     = '0;
            rr_en[d]    = 1'b0;
            man_rdy[d]  = 1'b1;
            for (int g = 0; g < 4; g++) begin
                gb[d][g] = '0;
                gt[d][g] = '0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) check_reset(d);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) check_reset(d);
        for (int d = 0; d < ND; d++) rr_en[d] = 1'b1;

        // Group 0 at its maximum, then all groups at maximum (overflow case).
        for (int d = 0; d < ND; d++) begin
            for (int g = 0; g < 4; g++) begin
                bv[g] = (g == 0) ? 7'h7F : 7'h00;
                tv[g] = (g == 0) ? 9'h1FF : 9'h000;
            end
            do_txn(d, 8'hA5, 8'h3C, bv, tv, 1, w);
            for (int g = 0; g < 4; g++) begin
                bv[g] = 7'h7F;
                tv[g] = 9'h1FF;
            end
            do_txn(d, 8'hFF, 8'hFF, bv, tv, 2, w);
            drain();
        end

        backpressure(0);
        drain();
        backpressure(2);
        drain();

        // Reset asserted in the second accumulate cycle.
        x_in[0] = 8'h5A;
        y_in[0] = 8'hC3;
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("pre_rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int g = 0; g < 4; g++) begin
            gb[0][g] = 7'h7F;
            gt[0][g] = 9'h1FF;
        end
        @(posedge clk); #2;
        chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) check_reset(d);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            bv[g] = 7'h00;
            tv[g] = (g == 1) ? 9'h001 : 9'h000;
        end
        do_txn(0, 8'h12, 8'h34, bv, tv, 1, w);
        drain();

        // Random traffic with random idle gaps and random out_ready.
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < ((d == 2) ? 200 : 40); i++) begin
                rand_txn(d, $urandom_range(0, 2));
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        fail("global_timeout", -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "simulation time limit reached");
    end

endmodule
